// File: rtl/muxn_rr_sel.sv
// Registered N-channel data selector with manual and round-robin grant modes.
// One-deep output register with valid/ready handshake and combinational per-channel ack.
module muxn_rr_sel #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ack,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    localparam int unsigned N_PAD = 1 << SEL_W;

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_PAD-1:0] valid_ext;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic             sel_bad;
    logic             man_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             slot_free;
    logic             load;
    logic [SEL_W-1:0] ptr_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Padding lets an out-of-range sel index the valid vector safely.
    assign valid_ext = N_PAD'(in_valid);
    assign sel_bad   = (32'(sel) >= N_CH);
    assign man_vld   = !sel_bad && valid_ext[sel];

    // First valid channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand   = '0;
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = SEL_W'((32'(rr_ptr) + k) % N_CH);
            if (!rr_vld && in_valid[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = man_vld;
            grant_idx = sel;
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign load      = !rst && slot_free && grant_vld;
    assign in_ack    = load ? (N_CH'(1) << grant_idx) : '0;
    assign ptr_next  = (32'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            sel_err <= !mode && sel_bad;
            if (load) begin
                out_data  <= ch_data[grant_idx];
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (mode) begin
                    rr_ptr <= ptr_next;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Ack is one-hot at most and only for channels offering a word.
    a_ack_onehot : assert property (@(posedge clk) $onehot0(in_ack));
    a_ack_valid  : assert property (@(posedge clk) (in_ack & ~in_valid) == '0);

endmodule
